sys_clk_ctrl: RTL and testbench
===============================

SYS_CLK_CTRL -- requirements
Module: sys_clk_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 16, divider counter width.
REQ-002 SHALL have parameter NUM_RATES, default 4, number of selectable rates, power of two, at least 2.
REQ-003 SHALL have parameter SEL_W, default 2, equal to log2(NUM_RATES).
REQ-004 SHALL have parameter CYC_W, default 32, enable-count width.
REQ-005 clk_100MHz  in  1  sole clock; one clock domain; reset is synchronous and active-high.
REQ-006 rst  in  1  synchronous active-high reset.
REQ-007 mode  in  2  00 halt, 01 run, 10 step, 11 burst.
REQ-008 rate_sel  in  SEL_W  selects divider slot.
REQ-009 rate_div  in  NUM_RATES*CNT_W  packed terminal counts; slot k is bits [k*CNT_W +: CNT_W].
REQ-010 step_req  in  1  host step/trigger level, asynchronous to clk_100MHz.
REQ-011 burst_len  in  16  enable pulses per burst.
REQ-012 cnt_clr  in  1  synchronous clear of cyc_count.
REQ-013 clk_en  out  1  one-cycle system clock-enable pulse.
REQ-014 busy  out  1  high while in RUN or BURST.
REQ-015 burst_done  out  1  one-cycle pulse at burst completion.
REQ-016 cyc_count  out  CYC_W  total clk_en pulses issued.

Function
REQ-017 SHALL synchronise step_req through 2 flops, then register once more for rising-edge detect; an edge SHALL be seen exactly 3 cycles after the step_req rise.
REQ-018 SHALL implement FSM states IDLE, RUN, STEP, BURST; reset state IDLE.
REQ-019 IDLE: mode 01 -> RUN; mode 10 and step edge -> STEP; mode 11 and step edge -> BURST, loading rem_cnt = burst_len; mode 00 stays IDLE.
REQ-020 div_cnt SHALL clear on entry to RUN/BURST, increment each cycle while in RUN/BURST, and reach terminal count when div_cnt == rate_div[rate_sel]; at terminal count it SHALL clear and raise clk_en for that cycle.
REQ-021 rate_div slot value 0 SHALL yield clk_en every cycle; value D SHALL yield period D+1 cycles; first pulse SHALL occur D+1 cycles after state entry.
REQ-022 A rate_sel change SHALL clear div_cnt on the following cycle; no pulse SHALL be produced in that cycle.
REQ-023 RUN: mode != 01 SHALL return to IDLE next cycle, no further clk_en.
REQ-024 STEP: SHALL assert clk_en for exactly one cycle (the cycle after the edge), then return to IDLE; step edges while not in IDLE SHALL be ignored.
REQ-025 BURST: each clk_en SHALL decrement rem_cnt; when the final pulse issues (rem_cnt 1 -> 0), the FSM SHALL assert burst_done next cycle and return to IDLE.
REQ-026 burst_len 0 SHALL produce burst_done the cycle after entry, with zero clk_en.
REQ-027 mode 00 during BURST SHALL abort to IDLE next cycle with no burst_done; other mode changes SHALL NOT affect an active burst.
REQ-028 cyc_count SHALL increment by 1 on each clk_en, wrapping from all-ones to 0.
REQ-029 cnt_clr SHALL zero cyc_count; clear SHALL win over a simultaneous clk_en.
REQ-030 busy SHALL be combinational from state (RUN or BURST); clk_en and burst_done SHALL be registered.

Reset
REQ-031 rst SHALL force state IDLE, and div_cnt, rem_cnt, sync flops, clk_en, burst_done, busy, and cyc_count to 0, in the cycle following its assertion.
REQ-032 rst SHALL override every input, including mid-burst and mid-run, with no trailing clk_en or burst_done.

Verification
REQ-033 Run: mode=01, rate_sel=1, slot1=3 -> clk_en every 4th cycle, first at cycle 4 after entry; cyc_count=5 after 5 pulses.
REQ-034 Step: mode=10, step_req pulsed high 10 cycles -> exactly one clk_en, 4 cycles after rise; holding step_req produces no further pulses.
REQ-035 Burst: mode=11, burst_len=3, slot0=0 -> 3 consecutive clk_en, burst_done 1 cycle after the third pulse, busy low afterward; burst_len=0 -> burst_done only.
REQ-036 Abort: burst_len=100, mode->00 after 10 pulses -> IDLE, cyc_count=10, no burst_done.
REQ-037 Wrap/clear: CYC_W=4, run 17 pulses -> cyc_count=1; cnt_clr coincident with clk_en -> cyc_count=0.
REQ-038 Reset mid-run: rst for 1 cycle during RUN -> all outputs 0 next cycle; RUN resumes, first pulse D+1 cycles after rst release.

Source files
------------

// File: rtl/sys_clk_ctrl.sv
// System clock-enable controller: divided run, single step and counted burst
// modes, with a synchronised host trigger and a running pulse counter.
module sys_clk_ctrl #(
  parameter int CNT_W     = 16,
  parameter int NUM_RATES = 4,
  parameter int SEL_W     = 2,
  parameter int CYC_W     = 32
) (
  input  logic                       clk_100MHz,
  input  logic                       rst,
  input  logic [1:0]                 mode,
  input  logic [SEL_W-1:0]           rate_sel,
  input  logic [NUM_RATES*CNT_W-1:0] rate_div,
  input  logic                       step_req,
  input  logic [15:0]                burst_len,
  input  logic                       cnt_clr,
  output logic                       clk_en,
  output logic                       busy,
  output logic                       burst_done,
  output logic [CYC_W-1:0]           cyc_count
);

  typedef enum logic [1:0] {IDLE, RUN, STEP, BURST} state_t;
  typedef enum logic [1:0] {
    M_HALT  = 2'b00,
    M_RUN   = 2'b01,
    M_STEP  = 2'b10,
    M_BURST = 2'b11
  } mode_t;

  state_t             state;
  logic [CNT_W-1:0]   div_cnt;
  logic [CNT_W-1:0]   cur_div;
  logic [15:0]        rem_cnt;
  logic [SEL_W-1:0]   rate_sel_q;
  logic               sync1, sync2, sync3;
  logic               step_edge;
  logic               rate_change;
  logic               term;
  logic               pulse;

  assign cur_div     = rate_div[rate_sel*CNT_W +: CNT_W];
  assign step_edge   = sync2 & ~sync3;
  assign rate_change = (rate_sel != rate_sel_q);
  // A rate change forces a divider restart, so it can never be a terminal count.
  assign term        = (div_cnt == cur_div) && !rate_change;
  assign busy        = (state == RUN) || (state == BURST);

  always_comb begin
    pulse = 1'b0;
    case (state)
      RUN:     pulse = (mode == M_RUN) && term;
      STEP:    pulse = 1'b1;
      BURST:   pulse = (mode != M_HALT) && (rem_cnt != 16'd0) && term;
      default: pulse = 1'b0;
    endcase
  end

  always_ff @(posedge clk_100MHz) begin
    if (rst) begin
      state      <= IDLE;
      div_cnt    <= '0;
      rem_cnt    <= '0;
      rate_sel_q <= '0;
      sync1      <= 1'b0;
      sync2      <= 1'b0;
      sync3      <= 1'b0;
      clk_en     <= 1'b0;
      burst_done <= 1'b0;
      cyc_count  <= '0;
    end else begin
      sync1      <= step_req;
      sync2      <= sync1;
      sync3      <= sync2;
      rate_sel_q <= rate_sel;
      clk_en     <= pulse;
      burst_done <= 1'b0;

      if (cnt_clr)
        cyc_count <= '0;
      else if (pulse)
        cyc_count <= cyc_count + CYC_W'(1);

      case (state)
        IDLE: begin
          div_cnt <= '0;
          if (mode == M_RUN) begin
            state <= RUN;
          end else if (step_edge && mode == M_STEP) begin
            state <= STEP;
          end else if (step_edge && mode == M_BURST) begin
            state   <= BURST;
            rem_cnt <= burst_len;
          end
        end
        RUN: begin
          if (mode != M_RUN) begin
            state <= IDLE;
          end else if (rate_change || term) begin
            div_cnt <= '0;
          end else begin
            div_cnt <= div_cnt + CNT_W'(1);
          end
        end
        STEP: begin
          state <= IDLE;
        end
        BURST: begin
          if (mode == M_HALT) begin
            state <= IDLE;
          end else if (rem_cnt == 16'd0) begin
            burst_done <= 1'b1;
            state      <= IDLE;
          end else if (rate_change || term) begin
            div_cnt <= '0;
            if (term)
              rem_cnt <= rem_cnt - 16'd1;
          end else begin
            div_cnt <= div_cnt + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sys_clk_ctrl.sv
// Directed bench for sys_clk_ctrl: expected pulse/done events are queued with
// their cycle numbers at stimulus time and matched against observed events.
module tb_sys_clk_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  mode;
  logic [1:0]  rate_sel;
  logic [63:0] rate_div;
  logic        step_req;
  logic [15:0] burst_len;
  logic        cnt_clr;
  logic        clk_en, busy, burst_done;
  logic [31:0] cyc_count;
  logic        clk_en4, busy4, burst_done4;
  logic [3:0]  cyc_count4;

  int unsigned cyc = 0;
  int          checks = 0;
  int          errors = 0;
  int unsigned model = 0;
  int unsigned base, e;
  longint      obs_q[$];
  longint      exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sys_clk_ctrl u_dut (
    .clk_100MHz(clk), .rst(rst), .mode(mode), .rate_sel(rate_sel),
    .rate_div(rate_div), .step_req(step_req), .burst_len(burst_len),
    .cnt_clr(cnt_clr), .clk_en(clk_en), .busy(busy),
    .burst_done(burst_done), .cyc_count(cyc_count)
  );

  sys_clk_ctrl #(.CYC_W(4)) u_w4 (
    .clk_100MHz(clk), .rst(rst), .mode(mode), .rate_sel(rate_sel),
    .rate_div(rate_div), .step_req(step_req), .burst_len(burst_len),
    .cnt_clr(cnt_clr), .clk_en(clk_en4), .busy(busy4),
    .burst_done(burst_done4), .cyc_count(cyc_count4)
  );

  // Event encoding: 2*cycle for clk_en, 2*cycle+1 for burst_done.
  always @(negedge clk) begin
    if (clk_en === 1'b1)     obs_q.push_back(2 * longint'(cyc));
    if (burst_done === 1'b1) obs_q.push_back(2 * longint'(cyc) + 1);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic push_pulses(input int unsigned first, input int unsigned period, input int unsigned n);
    for (int unsigned i = 0; i < n; i++)
      exp_q.push_back(2 * longint'(first + i * period));
    model += n;
  endtask

  task automatic push_done(input int unsigned c);
    exp_q.push_back(2 * longint'(c) + 1);
  endtask

  task automatic drain(input string tag);
    longint x, o;
    while (exp_q.size() > 0) begin
      x = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : -1;
      chk({tag, "_event"}, o, x);
    end
    chk({tag, "_extra"}, obs_q.size(), 0);
    obs_q.delete();
  endtask

  task automatic chk_count(input string tag);
    chk({tag, "_cnt"}, cyc_count, model);
    chk({tag, "_cnt4"}, cyc_count4, model & 32'hF);
  endtask

  initial begin
    rst = 1'b1; mode = 2'b00; rate_sel = 2'd0; step_req = 1'b0;
    burst_len = 16'd0; cnt_clr = 1'b0;
    rate_div = {16'd0, 16'd0, 16'd3, 16'd0};
    tick(3);
    chk("rst_clk_en", clk_en, 0);
    chk("rst_done", burst_done, 0);
    chk("rst_busy", busy, 0);
    chk_count("rst");
    rst = 1'b0;
    tick(1);

    // Run, slot1 = 3: period 4, first pulse 4 cycles after entry
    base = cyc; mode = 2'b01; rate_sel = 2'd1; e = base + 1;
    push_pulses(e + 4, 4, 5);
    tick(21);
    chk("run_busy", busy, 1);
    chk_count("run");
    mode = 2'b00;
    tick(3);
    chk("run_idle_busy", busy, 0);
    drain("run");

    // Rate change mid-run: one dead cycle, then restart from zero
    base = cyc; mode = 2'b01; rate_sel = 2'd0; e = base + 1;
    push_pulses(e + 1, 1, 2);
    tick(3);
    rate_sel = 2'd1;
    push_pulses(e + 7, 4, 2);
    tick(9);
    mode = 2'b00;
    tick(3);
    drain("ratesel");
    chk_count("ratesel");

    // Step: one pulse 4 cycles after the request rises, none while held
    base = cyc; mode = 2'b10; step_req = 1'b1;
    push_pulses(base + 4, 1, 1);
    tick(10);
    step_req = 1'b0;
    tick(10);
    chk("step_busy", busy, 0);
    drain("step");
    chk_count("step");

    // Burst of 3 at full rate
    rate_sel = 2'd0; burst_len = 16'd3;
    base = cyc; mode = 2'b11; step_req = 1'b1; e = base + 3;
    push_pulses(e + 1, 1, 3);
    push_done(e + 4);
    tick(5);
    chk("burst_busy", busy, 1);
    tick(2);
    chk("burst_done_lvl", burst_done, 1);
    chk("burst_end_busy", busy, 0);
    step_req = 1'b0;
    tick(4);
    drain("burst3");
    chk_count("burst3");

    // Zero-length burst: done only
    burst_len = 16'd0;
    base = cyc; step_req = 1'b1; e = base + 3;
    push_done(e + 1);
    tick(4);
    chk("burst0_done", burst_done, 1);
    chk("burst0_busy", busy, 0);
    step_req = 1'b0;
    tick(4);
    drain("burst0");

    // Abort a long burst after 10 pulses
    burst_len = 16'd100;
    base = cyc; step_req = 1'b1; e = base + 3;
    push_pulses(e + 1, 1, 10);
    tick(13);
    mode = 2'b00;
    tick(1);
    chk("abort_busy", busy, 0);
    step_req = 1'b0;
    tick(4);
    drain("abort");
    chk_count("abort");

    // Counter clear, then 17 pulses wraps the 4-bit instance to 1
    cnt_clr = 1'b1;
    tick(1);
    cnt_clr = 1'b0;
    model = 0;
    chk_count("clr");
    base = cyc; mode = 2'b01; rate_sel = 2'd0; e = base + 1;
    push_pulses(e + 1, 1, 17);
    tick(18);
    mode = 2'b00;
    chk_count("wrap");
    tick(3);
    drain("wrap");

    // Clear coincident with a pulse wins
    base = cyc; mode = 2'b01; e = base + 1;
    push_pulses(e + 1, 1, 3);
    tick(3);
    cnt_clr = 1'b1;
    tick(1);
    model = 0;
    chk("clrpulse_en", clk_en, 1);
    chk_count("clrpulse");
    cnt_clr = 1'b0; mode = 2'b00;
    tick(3);
    drain("clrpulse");

    // Reset on a cycle that would have pulsed, then run resumes
    base = cyc; mode = 2'b01; rate_sel = 2'd1; e = base + 1;
    push_pulses(e + 4, 4, 1);
    tick(8);
    rst = 1'b1;
    tick(1);
    model = 0;
    chk("mrst_clk_en", clk_en, 0);
    chk("mrst_done", burst_done, 0);
    chk("mrst_busy", busy, 0);
    chk_count("mrst");
    rst = 1'b0;
    push_pulses(e + 13, 4, 2);
    tick(9);
    chk_count("mrst_resume");
    mode = 2'b00;
    tick(3);
    drain("mrst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
